// File: rtl/keccak_byte_packer.sv
// keccak_byte_packer: byte-stream front end for the keccak SHA3-512 core.
// Packs message bytes big-endian into 32-bit words and sequences one message
// at a time: core reset pulse, word stream with final/pad word, digest wait.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   byte_in/_valid/_last/last_empty, byte_ready   byte-side handshake
//   core_reset          one-cycle reset pulse to the core before each message
//   core_in, core_in_ready, core_is_last, core_byte_num   word to the core
//   core_buffer_full    core cannot take a word this cycle
//   core_out_ready      digest valid
//   msg_done            one-cycle pulse when the digest becomes valid
module keccak_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_last,
  input  logic        last_empty,
  output logic        byte_ready,
  output logic        core_reset,
  output logic [31:0] core_in,
  output logic        core_in_ready,
  output logic        core_is_last,
  output logic [1:0]  core_byte_num,
  input  logic        core_buffer_full,
  input  logic        core_out_ready,
  output logic        msg_done
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BNUM_W = 2;
  localparam int unsigned SH_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FILL,
    S_TAIL,
    S_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sent_q, sent_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                vld_q, vld_d;
  logic                last_q, last_d;
  logic [BNUM_W-1:0]   bnum_q, bnum_d;
  logic                byte_ready_q, byte_ready_d;
  logic                core_reset_q, core_reset_d;
  logic                msg_done_q, msg_done_d;

  logic                xfer_c;
  logic                slot_free_c;
  logic                accept_c;
  logic [SH_W-1:0]     sh_c;
  logic [WORD_W-1:0]   acc_app_c;

  // Word handshake: a transfer frees the slot in the same cycle.
  assign xfer_c      = vld_q & ~core_buffer_full;
  assign slot_free_c = ~vld_q | ~core_buffer_full;
  assign accept_c    = byte_valid & byte_ready_q;

  // Byte k of the word lands in bits [31-8k -: 8].
  assign sh_c      = SH_W'(24) - {cnt_q[1:0], 3'b000};
  assign acc_app_c = acc_q | (WORD_W'(byte_in) << sh_c);

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sent_d     = sent_q;
    word_d     = word_q;
    vld_d      = vld_q;
    last_d     = last_q;
    bnum_d     = bnum_q;
    msg_done_d = 1'b0;

    if (xfer_c) vld_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (byte_valid) state_d = S_CLR;
      end
      S_CLR: begin
        acc_d   = '0;
        cnt_d   = '0;
        sent_d  = 1'b0;
        state_d = S_FILL;
      end
      S_FILL: begin
        if (accept_c) begin
          if (!(byte_last && last_empty)) begin
            acc_d = acc_app_c;
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (byte_last) begin
            state_d = S_TAIL;
          end else if (cnt_q == CNT_W'(3) && slot_free_c) begin
            // 4th byte goes straight to the word register when the slot allows.
            word_d = acc_app_c;
            vld_d  = 1'b1;
            last_d = 1'b0;
            bnum_d = '0;
            acc_d  = '0;
            cnt_d  = '0;
          end
        end else if (cnt_q == CNT_W'(4) && slot_free_c) begin
          word_d = acc_q;
          vld_d  = 1'b1;
          last_d = 1'b0;
          bnum_d = '0;
          acc_d  = '0;
          cnt_d  = '0;
        end
      end
      S_TAIL: begin
        if (!sent_q) begin
          if (slot_free_c) begin
            word_d = acc_q;
            vld_d  = 1'b1;
            if (cnt_q == CNT_W'(4)) begin
              // Full final word: send it plain, the cleared acc becomes the pad word.
              last_d = 1'b0;
              bnum_d = '0;
              acc_d  = '0;
              cnt_d  = '0;
            end else begin
              last_d = 1'b1;
              bnum_d = cnt_q[1:0];
              sent_d = 1'b1;
            end
          end
        end else if (xfer_c) begin
          sent_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_out_ready) begin
          msg_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_FILL) && (cnt_d != CNT_W'(4));
    core_reset_d = (state_d == S_CLR);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      sent_q       <= 1'b0;
      word_q       <= '0;
      vld_q        <= 1'b0;
      last_q       <= 1'b0;
      bnum_q       <= '0;
      byte_ready_q <= 1'b0;
      core_reset_q <= 1'b0;
      msg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      sent_q       <= sent_d;
      word_q       <= word_d;
      vld_q        <= vld_d;
      last_q       <= last_d;
      bnum_q       <= bnum_d;
      byte_ready_q <= byte_ready_d;
      core_reset_q <= core_reset_d;
      msg_done_q   <= msg_done_d;
    end
  end

  assign byte_ready    = byte_ready_q;
  assign core_reset    = core_reset_q;
  assign core_in       = word_q;
  assign core_in_ready = vld_q;
  assign core_is_last  = last_q;
  assign core_byte_num = bnum_q;
  assign msg_done      = msg_done_q;

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Directed bench for keccak_byte_packer: table of messages with hand-computed
// word streams, plus sequences for stall, mid-message reset and back-to-back.
`timescale 1ns/1ps
module tb_keccak_byte_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        last_empty;
  logic        byte_ready;
  logic        core_reset;
  logic [31:0] core_in;
  logic        core_in_ready;
  logic        core_is_last;
  logic [1:0]  core_byte_num;
  logic        core_buffer_full;
  logic        core_out_ready;
  logic        msg_done;

  keccak_byte_packer dut (
    .clk              (clk),
    .reset            (reset),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_last        (byte_last),
    .last_empty       (last_empty),
    .byte_ready       (byte_ready),
    .core_reset       (core_reset),
    .core_in          (core_in),
    .core_in_ready    (core_in_ready),
    .core_is_last     (core_is_last),
    .core_byte_num    (core_byte_num),
    .core_buffer_full (core_buffer_full),
    .core_out_ready   (core_out_ready),
    .msg_done         (msg_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0]  msg;        // message bytes, right-aligned, first byte most significant
    logic [7:0]   len;
    logic         empty_term; // terminate with an empty last beat
    logic [2:0]   nwords;
    logic [127:0] words;      // expected words, first in [127:96]
    logic [1:0]   bn;         // expected byte_num of the final word
  } vec_t;

  vec_t        vecs [8];
  vec_t        v;
  int          checks = 0;
  int          errors = 0;

  // Observations gathered at the falling edge.
  logic [34:0] xq [$];
  int          last_xfers = 0;
  int          rst_pulses = 0;
  int          done_cnt = 0;
  int          beats_acc = 0;
  int          stab_checks = 0;
  int          stab_viol = 0;
  logic        hold_prev = 1'b0;
  logic [34:0] held = '0;

  logic [7:0]  buf_b [64];
  int          buf_n;
  logic [34:0] fox_ref [$];
  string       tag;
  int          xb, lb, db, rb, bb, fw, w, t;
  bit          ok;

  always @(negedge clk) begin
    if (reset) begin
      if (core_in_ready && !core_buffer_full) begin
        xq.push_back({core_in, core_is_last, core_byte_num});
        if (core_is_last) last_xfers++;
      end
      if (core_reset) rst_pulses++;
      if (msg_done) done_cnt++;
      if (byte_valid && byte_ready) beats_acc++;
      if (hold_prev) begin
        stab_checks++;
        if (!core_in_ready || {core_in, core_is_last, core_byte_num} != held) stab_viol++;
      end
      hold_prev = core_in_ready && core_buffer_full;
      held      = {core_in, core_is_last, core_byte_num};
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] b, input bit last, input bit empty,
                           output int waits, output bit acc);
    logic rdy;
    byte_in = b; byte_last = last; last_empty = empty; byte_valid = 1'b1;
    acc = 1'b0; waits = 0;
    while (!acc && waits < 300) begin
      @(negedge clk);
      rdy = byte_ready;
      tick();
      if (rdy) acc = 1'b1;
      else waits++;
    end
    byte_valid = 1'b0; byte_last = 1'b0; last_empty = 1'b0;
  endtask

  task automatic send_buf(input int n, input bit empty_term, output int first_wait, output bit all_ok);
    int  wt;
    bit  a;
    all_ok = 1'b1;
    first_wait = -1;
    for (int i = 0; i < n; i++) begin
      send_beat(buf_b[i], (i == n - 1) && !empty_term, 1'b0, wt, a);
      if (i == 0) first_wait = wt;
      all_ok &= a;
    end
    if (empty_term) begin
      send_beat(8'h00, 1'b1, 1'b1, wt, a);
      if (n == 0) first_wait = wt;
      all_ok &= a;
    end
  endtask

  task automatic load_str(input string s);
    buf_n = s.len();
    for (int i = 0; i < buf_n; i++) buf_b[i] = s[i];
  endtask

  // Wait for the final word, hand back a digest and expect one msg_done.
  task automatic complete_msg(input string tg, input int last_base, input int done_base);
    int tt = 0;
    while (last_xfers == last_base && tt < 200) begin
      tick();
      tt++;
    end
    check_eq({tg, " last_word_seen"}, 64'(last_xfers - last_base), 64'd1);
    tick();
    core_out_ready = 1'b1;
    tick();
    core_out_ready = 1'b0;
    tick();
    tick();
    check_eq({tg, " msg_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
    check_eq({tg, " idle_byte_ready"}, 64'(byte_ready), 64'd0);
  endtask

  task automatic check_words(input string tg, input int base, input int n,
                             input logic [127:0] wds, input logic [1:0] bn);
    logic [34:0] exp;
    check_eq({tg, " word_count"}, 64'(xq.size() - base), 64'(n));
    for (int j = 0; j < n; j++) begin
      if (base + j < xq.size()) begin
        exp = {wds[127 - 32*j -: 32], (j == n - 1), (j == n - 1) ? bn : 2'd0};
        check_eq($sformatf("%s word%0d", tg, j), 64'(xq[base + j]), 64'(exp));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tg);
    check_eq({tg, " byte_ready"},    64'(byte_ready),    64'd0);
    check_eq({tg, " core_reset"},    64'(core_reset),    64'd0);
    check_eq({tg, " core_in"},       64'(core_in),       64'd0);
    check_eq({tg, " core_in_ready"}, 64'(core_in_ready), 64'd0);
    check_eq({tg, " core_is_last"},  64'(core_is_last),  64'd0);
    check_eq({tg, " core_byte_num"}, 64'(core_byte_num), 64'd0);
    check_eq({tg, " msg_done"},      64'(msg_done),      64'd0);
  endtask

  initial begin
    byte_in = '0; byte_valid = 1'b0; byte_last = 1'b0; last_empty = 1'b0;
    core_buffer_full = 1'b0; core_out_ready = 1'b0;

    vecs[0] = '{msg: 96'("abc"),      len: 8'd3, empty_term: 1'b0, nwords: 3'd1,
                words: {32'h61626300, 96'd0}, bn: 2'd3};
    vecs[1] = '{msg: 96'("Hell"),     len: 8'd4, empty_term: 1'b0, nwords: 3'd2,
                words: {32'h48656C6C, 32'h00000000, 64'd0}, bn: 2'd0};
    vecs[2] = '{msg: 96'd0,           len: 8'd0, empty_term: 1'b1, nwords: 3'd1,
                words: {32'h00000000, 96'd0}, bn: 2'd0};
    vecs[3] = '{msg: 96'("a"),        len: 8'd1, empty_term: 1'b0, nwords: 3'd1,
                words: {32'h61000000, 96'd0}, bn: 2'd1};
    vecs[4] = '{msg: 96'("ab"),       len: 8'd2, empty_term: 1'b1, nwords: 3'd1,
                words: {32'h61620000, 96'd0}, bn: 2'd2};
    vecs[5] = '{msg: 96'("Hello"),    len: 8'd5, empty_term: 1'b0, nwords: 3'd2,
                words: {32'h48656C6C, 32'h6F000000, 64'd0}, bn: 2'd1};
    vecs[6] = '{msg: 96'("abcd"),     len: 8'd4, empty_term: 1'b1, nwords: 3'd2,
                words: {32'h61626364, 32'h00000000, 64'd0}, bn: 2'd0};
    vecs[7] = '{msg: 96'("Hello wo"), len: 8'd8, empty_term: 1'b0, nwords: 3'd3,
                words: {32'h48656C6C, 32'h6F20776F, 32'h00000000, 32'd0}, bn: 2'd0};

    // Reset values, during and after reset.
    repeat (3) tick();
    check_reset_outputs("in_reset");
    reset = 1'b1;
    repeat (2) tick();
    check_reset_outputs("after_reset");

    // Table of single messages.
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      buf_n = int'(v.len);
      for (int k = 0; k < buf_n; k++) buf_b[k] = v.msg[8*(buf_n - 1 - k) +: 8];
      xb = xq.size(); lb = last_xfers; db = done_cnt; rb = rst_pulses;
      send_buf(buf_n, v.empty_term, fw, ok);
      tag = $sformatf("vec%0d", i);
      check_eq({tag, " accepted"}, 64'(ok), 64'd1);
      check_eq({tag, " first_byte_latency"}, 64'(fw), 64'd2);
      complete_msg(tag, lb, db);
      check_words(tag, xb, int'(v.nwords), v.words, v.bn);
      check_eq({tag, " core_reset_pulses"}, 64'(rst_pulses - rb), 64'd1);
    end

    // Fox: unstalled reference run.
    load_str("The quick brown fox jumps over the lazy dog.");
    xb = xq.size(); lb = last_xfers; db = done_cnt;
    send_buf(buf_n, 1'b0, fw, ok);
    complete_msg("fox_ref", lb, db);
    check_eq("fox_ref word_count", 64'(xq.size() - xb), 64'd12);
    for (int j = xb; j < xq.size(); j++) fox_ref.push_back(xq[j]);
    if (fox_ref.size() == 12) begin
      check_eq("fox_ref word0",  64'(fox_ref[0]),  64'({32'h54686520, 1'b0, 2'd0}));
      check_eq("fox_ref word10", 64'(fox_ref[10]), 64'({32'h646F672E, 1'b0, 2'd0}));
      check_eq("fox_ref word11", 64'(fox_ref[11]), 64'({32'h00000000, 1'b1, 2'd0}));
    end

    // Fox again with core_buffer_full high for 5 cycles mid-stream.
    xb = xq.size(); lb = last_xfers; db = done_cnt;
    fork
      send_buf(buf_n, 1'b0, fw, ok);
      begin
        repeat (14) tick();
        core_buffer_full = 1'b1;
        repeat (5) tick();
        core_buffer_full = 1'b0;
      end
    join
    check_eq("fox_stall accepted", 64'(ok), 64'd1);
    complete_msg("fox_stall", lb, db);
    check_eq("fox_stall word_count", 64'(xq.size() - xb), 64'(fox_ref.size()));
    for (int j = 0; j < fox_ref.size(); j++) begin
      if (xb + j < xq.size())
        check_eq($sformatf("fox_stall word%0d", j), 64'(xq[xb + j]), 64'(fox_ref[j]));
    end
    check_eq("fox_stall hold_observed", 64'(stab_checks > 0), 64'd1);
    check_eq("fox_stall hold_violations", 64'(stab_viol), 64'd0);

    // Abort after 6 bytes, then a full message.
    load_str("abcdef");
    for (int k = 0; k < 6; k++) send_beat(buf_b[k], 1'b0, 1'b0, w, ok);
    tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("abort");
    reset = 1'b1;
    tick();
    load_str("Hello world");
    xb = xq.size(); lb = last_xfers; db = done_cnt; rb = rst_pulses;
    send_buf(buf_n, 1'b0, fw, ok);
    check_eq("after_abort first_byte_latency", 64'(fw), 64'd2);
    complete_msg("after_abort", lb, db);
    check_words("after_abort", xb, 3, {32'h48656C6C, 32'h6F20776F, 32'h726C6400, 32'd0}, 2'd3);
    check_eq("after_abort core_reset_pulses", 64'(rst_pulses - rb), 64'd1);

    // Back-to-back: second message must wait for the first digest.
    load_str("abc");
    xb = xq.size(); lb = last_xfers;
    send_buf(buf_n, 1'b0, fw, ok);
    t = 0;
    while (last_xfers == lb && t < 200) begin
      tick();
      t++;
    end
    check_eq("b2b_a last_word_seen", 64'(last_xfers - lb), 64'd1);
    check_words("b2b_a", xb, 1, {32'h61626300, 96'd0}, 2'd3);
    load_str("Hell");
    xb = xq.size(); lb = last_xfers; db = done_cnt; rb = rst_pulses; bb = beats_acc;
    fork
      send_buf(buf_n, 1'b0, fw, ok);
      begin
        repeat (8) tick();
        check_eq("b2b_b held_beats", 64'(beats_acc - bb), 64'd0);
        check_eq("b2b_b held_byte_ready", 64'(byte_ready), 64'd0);
        check_eq("b2b_a done_before_digest", 64'(done_cnt - db), 64'd0);
        core_out_ready = 1'b1;
        tick();
        core_out_ready = 1'b0;
      end
    join
    check_eq("b2b_a msg_done_pulses", 64'(done_cnt - db), 64'd1);
    check_eq("b2b_b stalled_first_byte", 64'(fw > 8), 64'd1);
    check_eq("b2b_b beats", 64'(beats_acc - bb), 64'd4);
    complete_msg("b2b_b", lb, done_cnt);
    check_words("b2b_b", xb, 2, {32'h48656C6C, 32'h00000000, 64'd0}, 2'd0);
    check_eq("b2b_b core_reset_pulses", 64'(rst_pulses - rb), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
